operand_fetch: RTL and testbench

- Read-side companion to the 32-entry register file; sits between decode and execute.
- Accepts decoded instructions over a valid/ready handshake and drives the register file read addresses.
- Tracks outstanding destination writes in a 32-bit scoreboard and stalls on RAW/WAW hazards.
- Registers the fetched operands into an output pipeline stage with its own valid/ready handshake.

---
 rtl/operand_fetch_if.sv | 40 ++++
 rtl/operand_fetch.sv | 100 ++++++++++
 tb/tb_operand_fetch.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_fetch_if.sv
// Decode, register-file, writeback and execute-side signals of operand_fetch.
// master = surrounding pipeline, slave = operand_fetch.
interface operand_fetch_if #(parameter int WORD_SIZE = 32);
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [4:0]           in_rs1;
    logic [4:0]           in_rs2;
    logic [4:0]           in_rd;
    logic                 in_uses_rs1;
    logic                 in_uses_rs2;
    logic                 in_writes_rd;
    logic [4:0]           rf_rs1;
    logic [4:0]           rf_rs2;
    logic [WORD_SIZE-1:0] rf_rv1;
    logic [WORD_SIZE-1:0] rf_rv2;
    logic                 wb_en;
    logic [4:0]           wb_rd;
    logic [WORD_SIZE-1:0] wb_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [WORD_SIZE-1:0] out_op1;
    logic [WORD_SIZE-1:0] out_op2;
    logic [4:0]           out_rd;
    logic                 out_writes_rd;

    modport master (
        output flush, in_valid, in_rs1, in_rs2, in_rd, in_uses_rs1, in_uses_rs2,
               in_writes_rd, rf_rv1, rf_rv2, wb_en, wb_rd, wb_data, out_ready,
        input  in_ready, rf_rs1, rf_rs2, out_valid, out_op1, out_op2, out_rd,
               out_writes_rd
    );

    modport slave (
        input  flush, in_valid, in_rs1, in_rs2, in_rd, in_uses_rs1, in_uses_rs2,
               in_writes_rd, rf_rv1, rf_rv2, wb_en, wb_rd, wb_data, out_ready,
        output in_ready, rf_rs1, rf_rs2, out_valid, out_op1, out_op2, out_rd,
               out_writes_rd
    );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch stage: busy-bit scoreboard, RAW/WAW stall, registered operand bundle.
// Optional macro OPERAND_BYPASS_EN forwards same-cycle writeback data to the operands.
module operand_fetch #(
    parameter int WORD_SIZE = 32
) (
    input  logic          clk,
    input  logic          rst,
    operand_fetch_if.slave bus
);
    logic [31:0]          busy;
    logic [31:0]          busy_nxt;
    logic                 wb_clr;
    logic                 byp1;
    logic                 byp2;
    logic                 bypd;
    logic                 h1;
    logic                 h2;
    logic                 hd;
    logic                 stall;
    logic                 issue;
    logic [WORD_SIZE-1:0] src1;
    logic [WORD_SIZE-1:0] src2;
    logic [WORD_SIZE-1:0] op1_nxt;
    logic [WORD_SIZE-1:0] op2_nxt;

    assign bus.rf_rs1 = bus.in_rs1;
    assign bus.rf_rs2 = bus.in_rs2;

    assign wb_clr = bus.wb_en && (bus.wb_rd != 5'd0);

`ifdef OPERAND_BYPASS_EN
    assign byp1 = wb_clr && (bus.wb_rd == bus.in_rs1);
    assign byp2 = wb_clr && (bus.wb_rd == bus.in_rs2);
    assign bypd = wb_clr && (bus.wb_rd == bus.in_rd);
    assign src1 = byp1 ? bus.wb_data : bus.rf_rv1;
    assign src2 = byp2 ? bus.wb_data : bus.rf_rv2;
`else
    // Writeback data only matters to the register file itself in this build.
    logic unused_wb_data;
    assign unused_wb_data = ^bus.wb_data;
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
    assign bypd = 1'b0;
    assign src1 = bus.rf_rv1;
    assign src2 = bus.rf_rv2;
`endif

    assign h1    = bus.in_uses_rs1  && busy[bus.in_rs1] && !byp1;
    assign h2    = bus.in_uses_rs2  && busy[bus.in_rs2] && !byp2;
    assign hd    = bus.in_writes_rd && busy[bus.in_rd]  && !bypd;
    assign stall = h1 || h2 || hd;

    assign bus.in_ready = !stall && !bus.flush && (!bus.out_valid || bus.out_ready);
    assign issue        = bus.in_valid && bus.in_ready;

    assign op1_nxt = (bus.in_uses_rs1 && (bus.in_rs1 != 5'd0)) ? src1 : '0;
    assign op2_nxt = (bus.in_uses_rs2 && (bus.in_rs2 != 5'd0)) ? src2 : '0;

    // Set is applied after clear so a same-index set wins.
    always_comb begin
        busy_nxt = busy;
        if (wb_clr) begin
            busy_nxt[bus.wb_rd] = 1'b0;
        end
        if (issue && bus.in_writes_rd && (bus.in_rd != 5'd0)) begin
            busy_nxt[bus.in_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
        end else if (bus.flush) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.out_valid     <= 1'b0;
            bus.out_op1       <= '0;
            bus.out_op2       <= '0;
            bus.out_rd        <= 5'd0;
            bus.out_writes_rd <= 1'b0;
        end else if (bus.flush) begin
            bus.out_valid <= 1'b0;
        end else if (issue) begin
            bus.out_valid     <= 1'b1;
            bus.out_op1       <= op1_nxt;
            bus.out_op2       <= op2_nxt;
            bus.out_rd        <= bus.in_rd;
            bus.out_writes_rd <= bus.in_writes_rd;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: register-file model plus a queue of expected
// operand bundles pushed at issue and compared at the output handshake.
module tb_operand_fetch;
    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] op1;
        logic [W-1:0] op2;
        logic [4:0]   rd;
        logic         wr;
    } bundle_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    int           n_chk = 0;
    int           n_err = 0;
    bit           issued = 1'b0;
    bundle_t      exp_q[$];
    logic [W-1:0] rf[32];

    operand_fetch_if #(.WORD_SIZE(W)) bus ();
    operand_fetch #(.WORD_SIZE(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    assign bus.rf_rv1 = rf[bus.rf_rs1];
    assign bus.rf_rv2 = rf[bus.rf_rs2];

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model_op(input logic uses, input logic [4:0] idx);
        if (!uses || idx == 5'd0) return '0;
`ifdef OPERAND_BYPASS_EN
        if (bus.wb_en && bus.wb_rd == idx) return bus.wb_data;
`endif
        return rf[idx];
    endfunction

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic step();
        bundle_t      b;
        bundle_t      e;
        logic         wbe;
        logic         fl;
        logic [4:0]   wrd;
        logic [W-1:0] wdat;
        #1;
        issued = 1'b0;
        if (bus.in_valid && bus.in_ready) begin
            b.op1 = model_op(bus.in_uses_rs1, bus.in_rs1);
            b.op2 = model_op(bus.in_uses_rs2, bus.in_rs2);
            b.rd  = bus.in_rd;
            b.wr  = bus.in_writes_rd;
            exp_q.push_back(b);
            issued = 1'b1;
        end
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk_val("spurious_out", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk_val("sb_op1", bus.out_op1, e.op1);
                chk_val("sb_op2", bus.out_op2, e.op2);
                chk_val("sb_rd", bus.out_rd, e.rd);
                chk_val("sb_wr", bus.out_writes_rd, e.wr);
            end
        end
        wbe  = bus.wb_en;
        wrd  = bus.wb_rd;
        wdat = bus.wb_data;
        fl   = bus.flush;
        @(posedge clk);
        if (wbe && wrd != 5'd0) rf[wrd] = wdat;
        if (fl) exp_q.delete();
        @(negedge clk);
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic u1, input logic u2, input logic wr);
        bus.in_rs1       = rs1;
        bus.in_rs2       = rs2;
        bus.in_rd        = rd;
        bus.in_uses_rs1  = u1;
        bus.in_uses_rs2  = u2;
        bus.in_writes_rd = wr;
        bus.in_valid     = 1'b1;
    endtask

    task automatic send(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic u1, input logic u2, input logic wr, input string tag);
        drive(rs1, rs2, rd, u1, u2, wr);
        issued = 1'b0;
        for (int i = 0; i < 4 && !issued; i++) step();
        if (!issued) chk_val({tag, "_timeout"}, 64'd0, 64'd1);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = W'(i * 256);
        rf[0] = 32'hFFFF;
        rf[3] = 32'h11;
        rf[4] = 32'h22;
        bus.flush = 1'b0;
        bus.wb_en = 1'b0;
        bus.wb_rd = 5'd0;
        bus.wb_data = '0;
        bus.out_ready = 1'b0;
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        bus.in_valid = 1'b0;

        // Reset state and combinational read addresses
        repeat (2) @(negedge clk);
        bus.in_rs1 = 5'd3;
        bus.in_rs2 = 5'd4;
        #1;
        chk_val("rst_out_valid", bus.out_valid, 64'd0);
        chk_val("rst_out_op1", bus.out_op1, 64'd0);
        chk_val("rst_out_op2", bus.out_op2, 64'd0);
        chk_val("rst_out_rd", bus.out_rd, 64'd0);
        chk_val("rst_out_wr", bus.out_writes_rd, 64'd0);
        chk_val("rf_rs1", bus.rf_rs1, 64'd3);
        chk_val("rf_rs2", bus.rf_rs2, 64'd4);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // 1: basic issue, one-cycle latency
        bus.out_ready = 1'b1;
        send(5'd3, 5'd4, 5'd1, 1'b1, 1'b1, 1'b0, "t1");
        chk_val("t1_out_valid", bus.out_valid, 64'd1);
        chk_val("t1_op1", bus.out_op1, 64'h11);
        chk_val("t1_op2", bus.out_op2, 64'h22);
        step();

        // 2: RAW stall until writeback
        send(5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, "t2a");
        drive(5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);
        #1 chk_val("t2_stall0", bus.in_ready, 64'd0);
        step();
        #1 chk_val("t2_stall1", bus.in_ready, 64'd0);
        step();
        bus.wb_en = 1'b1;
        bus.wb_rd = 5'd5;
        bus.wb_data = 32'hABCD;
`ifdef OPERAND_BYPASS_EN
        #1 chk_val("t2_wb_cycle_ready", bus.in_ready, 64'd1);
        step();
        bus.wb_en = 1'b0;
        chk_val("t2_issued_in_wb", issued, 64'd1);
`else
        #1 chk_val("t2_wb_cycle_ready", bus.in_ready, 64'd0);
        step();
        bus.wb_en = 1'b0;
        chk_val("t2_no_issue_in_wb", issued, 64'd0);
        #1 chk_val("t2_ready_after_wb", bus.in_ready, 64'd1);
        step();
        chk_val("t2_issued_after_wb", issued, 64'd1);
`endif
        bus.in_valid = 1'b0;
        chk_val("t2_op1", bus.out_op1, 64'hABCD);
        step();

        // 3: x0 is never busy and always reads as zero
        send(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, "t3a");
        drive(5'd0, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0);
        #1 chk_val("t3_no_stall", bus.in_ready, 64'd1);
        step();
        chk_val("t3_issued", issued, 64'd1);
        bus.in_valid = 1'b0;
        chk_val("t3_op1_zero", bus.out_op1, 64'd0);
        step();

        // 4: backpressure holds the bundle and blocks issue
        bus.out_ready = 1'b0;
        send(5'd3, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0, "t4x");
        drive(5'd4, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_val("t4_ready_low", bus.in_ready, 64'd0);
            chk_val("t4_hold_valid", bus.out_valid, 64'd1);
            chk_val("t4_hold_op1", bus.out_op1, 64'h11);
            step();
        end
        bus.out_ready = 1'b1;
        #1 chk_val("t4_ready_high", bus.in_ready, 64'd1);
        step();
        chk_val("t4_y_issued", issued, 64'd1);
        bus.in_valid = 1'b0;
        chk_val("t4_y_op1", bus.out_op1, 64'h22);
        chk_val("t4_y_rd", bus.out_rd, 64'd8);
        step();

        // 5: WAW stall, then flush clears output stage and scoreboard
        bus.out_ready = 1'b0;
        send(5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, "t5a");
        drive(5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1);
        #1 chk_val("t5_waw_stall", bus.in_ready, 64'd0);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.flush = 1'b1;
        #1 chk_val("t5_flush_ready", bus.in_ready, 64'd0);
        step();
        bus.flush = 1'b0;
        chk_val("t5_flush_valid", bus.out_valid, 64'd0);
        drive(5'd7, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        #1 chk_val("t5_busy_cleared", bus.in_ready, 64'd1);
        step();
        chk_val("t5_issued", issued, 64'd1);
        bus.in_valid = 1'b0;
        chk_val("t5_op1", bus.out_op1, 64'h700);
        step();

        // 6: asynchronous reset mid-cycle
        bus.out_ready = 1'b0;
        send(5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, "t6a");
        chk_val("t6_pre_valid", bus.out_valid, 64'd1);
        #3 rst = 1'b0;
        #1;
        chk_val("t6_rst_valid", bus.out_valid, 64'd0);
        chk_val("t6_rst_rd", bus.out_rd, 64'd0);
        chk_val("t6_rst_wr", bus.out_writes_rd, 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        bus.out_ready = 1'b1;
        drive(5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        #1 chk_val("t6_busy9_clear", bus.in_ready, 64'd1);
        step();
        chk_val("t6_issued", issued, 64'd1);
        bus.in_valid = 1'b0;
        chk_val("t6_op1", bus.out_op1, 64'h900);
        step();

        chk_val("queue_drained", exp_q.size(), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
